// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one iterative 32x32->64 multiplier; grant->start 1 cycle, done->resp 1 cycle; resp stalls hold everything.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN (resp_err=1, resp_r=0 on expiry).
module mul_share_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int IDW            = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [63:0]           resp_r,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mul_valid_in,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_valid_out,
  input  logic [63:0]           mul_r
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] next_ptr;
  logic [IDW:0]   scan;
  logic           found;
  logic           grant;

  // Scan from the highest offset down so the closest requester to ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(N_REQ)) scan = scan - (IDW+1)'(N_REQ);
      if (req_valid[scan[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDW-1:0];
      end
    end
  end

  assign grant     = (state == S_IDLE) && found;
  assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
  assign next_ptr  = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  // The watchdog limit has no effect in this build.
  assign resp_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      resp_r       <= '0;
      resp_id      <= '0;
      resp_valid   <= 1'b0;
      busy         <= 1'b0;
      mul_valid_in <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      resp_err     <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            mul_a        <= req_a[32*winner +: 32];
            mul_b        <= req_b[32*winner +: 32];
            resp_id      <= winner;
            ptr          <= next_ptr;
            busy         <= 1'b1;
            mul_valid_in <= 1'b1;
            state        <= S_ISSUE;
`ifdef MUL_ARB_TIMEOUT_EN
            resp_err     <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          mul_valid_in <= 1'b0;
          state        <= S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_valid_out) begin
            resp_r     <= mul_r;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            resp_r     <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt   <= wait_cnt + TW'(1);
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: reset, round robin, single request, back-pressure, max operands, reset mid-WAIT, watchdog.
module tb_mul_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [63:0]     resp_r;
  logic            resp_err;
  logic            busy;
  logic            mul_valid_in;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic            mul_valid_out;
  logic [63:0]     mul_r;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [63:0] rr_prod [4] = '{64'd6, 64'd12, 64'd20, 64'd30};

  mul_share_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_r(resp_r), .resp_err(resp_err), .busy(busy),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_r(mul_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // External multiplier model: called in the ISSUE cycle, completes after lat WAIT cycles.
  task automatic run_mul(input int lat);
    logic [63:0] prod;
    prod = {32'b0, mul_a} * {32'b0, mul_b};
    repeat (lat) tick();
    mul_valid_out = 1'b1;
    mul_r         = prod;
    tick();
    mul_valid_out = 1'b0;
    mul_r         = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0; mul_valid_out = 1'b0; mul_r = '0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_valid_in", mul_valid_in, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_resp_r", resp_r, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b0;

    // Round robin: everyone requesting, consumer always ready.
    for (int i = 0; i < N; i++) set_ops(i, 32'(i + 2), 32'(i + 3));
    req_valid = '1; resp_ready = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      int g;
      logic [N-1:0] e;
      g = t % N;
      e = 4'b0001 << g;
      chk("rr_grant", req_ready, e);
      tick();
      chk("rr_issue", mul_valid_in, 1);
      chk("rr_id", resp_id, g);
      run_mul(1);
      chk("rr_resp_valid", resp_valid, 1);
      chk("rr_prod", resp_r, rr_prod[g]);
      chk("rr_no_grant_in_resp", req_ready, 0);
      if (t == 4) req_valid = '0;
      tick();
      chk("rr_resp_one_cycle", resp_valid, 0);
    end

    // Single request from requester 2, then back-pressure.
    resp_ready = 1'b0;
    set_ops(2, 32'd7, 32'd9);
    req_valid = 4'b0100;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    tick();
    chk("single_mvi", mul_valid_in, 1);
    chk("single_busy", busy, 1);
    chk("single_mul_a", mul_a, 7);
    chk("single_mul_b", mul_b, 9);
    chk("single_ready_off", req_ready, 0);
    req_valid = '0;
    tick();
    chk("single_mvi_pulse", mul_valid_in, 0);
    repeat (3) tick();
    chk("single_wait", resp_valid, 0);
    mul_valid_out = 1'b1;
    mul_r = {32'b0, mul_a} * {32'b0, mul_b};
    tick();
    mul_valid_out = 1'b0; mul_r = '0;
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_r", resp_r, 64'd63);
    chk("single_resp_id", resp_id, 2);

    req_valid = 4'b0001;
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_r", resp_r, 64'd63);
      chk("bp_id", resp_id, 2);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    resp_ready = 1'b1;
    #1;
    chk("accept_no_grant", req_ready, 0);
    tick();
    chk("accept_idle_valid", resp_valid, 0);
    chk("accept_idle_busy", busy, 0);
    chk("accept_next_grant", req_ready, 4'b0001);

    // Max operands on requester 0.
    tick();
    req_valid = '0;
    chk("max_id", resp_id, 0);
    chk("max_mul_a", mul_a, 32'hFFFF_FFFF);
    run_mul(2);
    chk("max_prod", resp_r, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Reset two cycles after the start pulse.
    set_ops(1, 32'd5, 32'd6);
    req_valid = 4'b0010;
    #1;
    chk("mr_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_mvi", mul_valid_in, 0);
    chk("mr_mul_a", mul_a, 0);
    chk("mr_mul_b", mul_b, 0);
    chk("mr_resp_r", resp_r, 0);
    chk("mr_resp_id", resp_id, 0);
    chk("mr_req_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    mul_valid_out = 1'b1; mul_r = 64'd30;
    tick();
    mul_valid_out = 1'b0; mul_r = '0;
    chk("mr_late_done_valid", resp_valid, 0);
    chk("mr_late_done_busy", busy, 0);
    tick();
    chk("mr_late_done_valid2", resp_valid, 0);
    req_valid = '1;
    #1;
    chk("mr_ptr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("mr_post_id", resp_id, 0);
    run_mul(1);
    chk("mr_post_prod", resp_r, 64'hFFFF_FFFE_0000_0001);
    tick();

`ifdef MUL_ARB_TIMEOUT_EN
    set_ops(3, 32'd11, 32'd13);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    chk("to_id", resp_id, 3);
    repeat (64) tick();
    chk("to_still_wait", resp_valid, 0);
    tick();
    chk("to_valid", resp_valid, 1);
    chk("to_err", resp_err, 1);
    chk("to_r", resp_r, 0);
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("to_err_cleared", resp_err, 0);
    run_mul(1);
    chk("to_next_r", resp_r, 64'd63);
    chk("to_next_err", resp_err, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
